router_pkt_ctrl: RTL and testbench
==================================

# router_pkt_ctrl

Packet-sequencing controller for the 1x3 router. It watches the source handshake (`pkt_valid`), decodes the 2-bit destination in the header, and steps the register/synchroniser datapath through header, payload, parity and FIFO-full phases. It also honours per-port soft resets from the sync block. It sits between the input source and the router register and sync blocks, driving their load and enable strobes.

## Interface
Parameters:
- `WAIT_LIMIT`, default 30: cycles allowed in WAIT_TILL_EMPTY before timeout. Used only with the timeout macro.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `pkt_valid` in 1: source asserts for header and payload; drops on the parity byte.
- `data_in` in 2: header destination field; 0/1/2 are valid ports, 3 is invalid.
- `fifo_full` in 1: full flag of the currently addressed FIFO, from the sync block.
- `fifo_empty_0/1/2` in 1 each: empty flags of the three output FIFOs.
- `soft_reset_0/1/2` in 1 each: per-port soft reset from the sync block.
- `parity_done` in 1: register block has latched the parity byte.
- `low_pkt_valid` in 1: register block saw `pkt_valid` fall while stalled.
- `detect_add` out 1: high in DECODE_ADDRESS.
- `lfd_state` out 1: high in LOAD_FIRST_DATA.
- `ld_state` out 1: high in LOAD_DATA.
- `laf_state` out 1: high in LOAD_AFTER_FULL.
- `full_state` out 1: high in FIFO_FULL_STATE.
- `rst_int_reg` out 1: high in CHECK_PARITY_ERROR.
- `write_enb_reg` out 1: high in LOAD_DATA, LOAD_PARITY or LOAD_AFTER_FULL.
- `busy` out 1: source stall; high in LOAD_FIRST_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY and CHECK_PARITY_ERROR.
- `wait_timeout` out 1: one-cycle pulse when the WAIT_TILL_EMPTY timeout fires.

## Operation
- The state machine has 9 states, 4-bit encoded, and is Moore-type: every output decodes from the state register only.
- Address register `addr_q[1:0]` loads `data_in` when the state is DECODE_ADDRESS and `pkt_valid` is high.
- `empty_sel` is the `fifo_empty_*` flag selected by `data_in` in DECODE_ADDRESS and by `addr_q` in all other states.
- `sr_sel` is the `soft_reset_*` flag selected by `addr_q`.

Transitions:
- DECODE_ADDRESS:
  - `pkt_valid`, `data_in` = 3 → DROP_PKT.
  - `pkt_valid`, valid `data_in`, `empty_sel` = 1 → LOAD_FIRST_DATA.
  - `pkt_valid`, valid `data_in`, `empty_sel` = 0 → WAIT_TILL_EMPTY.
  - Otherwise hold.
- LOAD_FIRST_DATA → LOAD_DATA, unconditionally.
- LOAD_DATA:
  - `fifo_full` → FIFO_FULL_STATE.
  - Else `!pkt_valid` → LOAD_PARITY.
  - Else hold.
- FIFO_FULL_STATE: `!fifo_full` → LOAD_AFTER_FULL; else hold.
- LOAD_AFTER_FULL:
  - `parity_done` → DECODE_ADDRESS.
  - Else `low_pkt_valid` → LOAD_PARITY.
  - Else → LOAD_DATA.
- LOAD_PARITY → CHECK_PARITY_ERROR, unconditionally.
- CHECK_PARITY_ERROR: `fifo_full` → FIFO_FULL_STATE; else → DECODE_ADDRESS.
- WAIT_TILL_EMPTY: `empty_sel` → LOAD_FIRST_DATA; else hold.
- DROP_PKT: `!pkt_valid` → DECODE_ADDRESS; else hold. Bytes seen in this state are discarded; `busy` = 0.

Soft reset:
- `sr_sel` = 1 in any state other than DECODE_ADDRESS or DROP_PKT forces DECODE_ADDRESS on the next edge.
- Soft reset overrides every other transition.

## Timing
- Reset values: state is DECODE_ADDRESS, so `detect_add` = 1. All other outputs = 0 and `addr_q` = 0.
- `reset` overrides soft reset and every transition. Asserting it mid-packet returns the controller to DECODE_ADDRESS on the next edge and discards `addr_q`.
- Outputs change one cycle after the qualifying input edge; there is no combinational input-to-output path.
- A header accepted at edge N gives `lfd_state` = 1 in cycle N+1 and `ld_state` = 1 in cycle N+2.
- The address is sampled only in DECODE_ADDRESS. `data_in` changes in later states are ignored.
- `fifo_full` and `!pkt_valid` together in LOAD_DATA: `fifo_full` wins, and the parity byte is handled via LOAD_AFTER_FULL with `low_pkt_valid`.
- A soft reset and `empty_sel` in the same cycle of WAIT_TILL_EMPTY: soft reset wins.

## Configuration
- Macro `ROUTER_CTRL_WAIT_TIMEOUT_EN`.
- Defined:
  - A counter of width `$clog2(WAIT_LIMIT+1)` clears on entry to WAIT_TILL_EMPTY and increments each cycle spent there.
  - When it reaches `WAIT_LIMIT` with `empty_sel` still 0, the state goes to DROP_PKT and `wait_timeout` pulses for 1 cycle.
  - `empty_sel` on the limit cycle wins over the timeout.
- Undefined: the counter is absent, WAIT_TILL_EMPTY waits indefinitely, and `wait_timeout` is tied to 0.

## Test plan
- Reset, then `pkt_valid`=1 with `data_in`=1 and `fifo_empty_1`=1 → `detect_add` → `lfd_state` → `ld_state` on three consecutive cycles. `pkt_valid`=0 → one cycle of LOAD_PARITY with `busy`=1, then CHECK_PARITY_ERROR with `rst_int_reg`=1, then DECODE_ADDRESS.
- Header with `data_in`=0 and `fifo_empty_0`=0 → WAIT_TILL_EMPTY with `busy`=1. Set `fifo_empty_0`=1 → next cycle `lfd_state`=1.
- In LOAD_DATA, `fifo_full`=1 for 3 cycles → `full_state`=1 for 3 cycles. Release → `laf_state`=1. Then `low_pkt_valid`=1 → LOAD_PARITY; or `parity_done`=1 → DECODE_ADDRESS.
- Header with `data_in`=3 while `pkt_valid` is held 5 cycles → DROP_PKT with `busy`=0 and `write_enb_reg`=0 throughout. `pkt_valid`=0 → DECODE_ADDRESS.
- Packet to port 2 in LOAD_DATA, `soft_reset_2`=1 → DECODE_ADDRESS next cycle. `soft_reset_0` pulses in the same run are ignored.
- With `ROUTER_CTRL_WAIT_TIMEOUT_EN` and `WAIT_LIMIT`=30: header to non-empty port 1, `fifo_empty_1` held 0 → `wait_timeout` pulse after 30 cycles in WAIT_TILL_EMPTY, then DROP_PKT. Without the macro → still WAIT_TILL_EMPTY after 100 cycles.

Source files
------------

// File: rtl/router_pkt_ctrl.sv
// router_pkt_ctrl: packet-sequencing controller for the 1x3 router.
// Steps the register/sync datapath through header, payload, parity and
// FIFO-full phases, and honours per-port soft resets from the sync block.
// Optional feature macro: ROUTER_CTRL_WAIT_TIMEOUT_EN enables a bounded wait
// in WAIT_TILL_EMPTY that drops the packet after WAIT_LIMIT cycles.
module router_pkt_ctrl #(
   parameter int WAIT_LIMIT = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pkt_valid,
   input  logic [1:0] data_in,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       soft_reset_0,
   input  logic       soft_reset_1,
   input  logic       soft_reset_2,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       rst_int_reg,
   output logic       write_enb_reg,
   output logic       busy,
   output logic       wait_timeout
);

   typedef enum logic [3:0] {
      DECODE_ADDRESS     = 4'd0,
      LOAD_FIRST_DATA    = 4'd1,
      LOAD_DATA          = 4'd2,
      LOAD_PARITY        = 4'd3,
      FIFO_FULL_STATE    = 4'd4,
      LOAD_AFTER_FULL    = 4'd5,
      WAIT_TILL_EMPTY    = 4'd6,
      CHECK_PARITY_ERROR = 4'd7,
      DROP_PKT           = 4'd8
   } state_t;

   state_t     r_state;
   state_t     w_nextState;
   logic [1:0] r_addr;
   logic [1:0] w_emptyIdx;
   logic       w_emptySel;
   logic       w_srSel;
   logic       w_softReset;
   logic       w_timeoutFire;

   // Empty flag of the port being addressed: the live header field while
   // decoding, the latched address once the packet is under way.
   always_comb begin
      w_emptyIdx = (r_state == DECODE_ADDRESS) ? data_in : r_addr;
      w_emptySel = 1'b0;
      case (w_emptyIdx)
         2'd0:    w_emptySel = fifo_empty_0;
         2'd1:    w_emptySel = fifo_empty_1;
         2'd2:    w_emptySel = fifo_empty_2;
         default: w_emptySel = 1'b0;
      endcase
   end

   // Soft reset of the latched port; address 3 has no port and never resets.
   always_comb begin
      w_srSel = 1'b0;
      case (r_addr)
         2'd0:    w_srSel = soft_reset_0;
         2'd1:    w_srSel = soft_reset_1;
         2'd2:    w_srSel = soft_reset_2;
         default: w_srSel = 1'b0;
      endcase
   end

   // Soft reset only aborts a packet in progress; idle and dropping states
   // have no FIFO traffic to abandon.
   assign w_softReset = w_srSel && (r_state != DECODE_ADDRESS) && (r_state != DROP_PKT);

`ifdef ROUTER_CTRL_WAIT_TIMEOUT_EN
   localparam int CW = $clog2(WAIT_LIMIT + 1);

   logic [CW-1:0] r_waitCnt;
   logic [CW-1:0] w_cntInc;

   assign w_cntInc      = r_waitCnt + 1'b1;
   assign w_timeoutFire = (r_state == WAIT_TILL_EMPTY) && !w_emptySel &&
                          (w_cntInc == CW'(WAIT_LIMIT));

   // Count cycles spent waiting; the count restarts every time the state is entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_waitCnt <= '0;
      end else if (r_state == WAIT_TILL_EMPTY) begin
         r_waitCnt <= w_cntInc;
      end else begin
         r_waitCnt <= '0;
      end
   end
`else
   logic w_unusedLimit;

   assign w_unusedLimit = (WAIT_LIMIT > 0);
   assign w_timeoutFire = 1'b0;
`endif

   // Next-state selection; soft reset overrides every ordinary transition.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         DECODE_ADDRESS: begin
            if (pkt_valid) begin
               if (data_in == 2'd3)  w_nextState = DROP_PKT;
               else if (w_emptySel)  w_nextState = LOAD_FIRST_DATA;
               else                  w_nextState = WAIT_TILL_EMPTY;
            end
         end
         LOAD_FIRST_DATA: w_nextState = LOAD_DATA;
         LOAD_DATA: begin
            if (fifo_full)       w_nextState = FIFO_FULL_STATE;
            else if (!pkt_valid) w_nextState = LOAD_PARITY;
         end
         FIFO_FULL_STATE: begin
            if (!fifo_full) w_nextState = LOAD_AFTER_FULL;
         end
         LOAD_AFTER_FULL: begin
            if (parity_done)        w_nextState = DECODE_ADDRESS;
            else if (low_pkt_valid) w_nextState = LOAD_PARITY;
            else                    w_nextState = LOAD_DATA;
         end
         LOAD_PARITY: w_nextState = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: begin
            if (fifo_full) w_nextState = FIFO_FULL_STATE;
            else           w_nextState = DECODE_ADDRESS;
         end
         WAIT_TILL_EMPTY: begin
            if (w_emptySel)         w_nextState = LOAD_FIRST_DATA;
            else if (w_timeoutFire) w_nextState = DROP_PKT;
         end
         DROP_PKT: begin
            if (!pkt_valid) w_nextState = DECODE_ADDRESS;
         end
         default: w_nextState = DECODE_ADDRESS;
      endcase
      if (w_softReset) w_nextState = DECODE_ADDRESS;
   end

   // Latch the destination port when a header is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr <= 2'd0;
      end else if ((r_state == DECODE_ADDRESS) && pkt_valid) begin
         r_addr <= data_in;
      end
   end

   // State register with outputs decoded from the next state, so every
   // strobe is a flop that tracks the state it belongs to.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= DECODE_ADDRESS;
         detect_add    <= 1'b1;
         lfd_state     <= 1'b0;
         ld_state      <= 1'b0;
         laf_state     <= 1'b0;
         full_state    <= 1'b0;
         rst_int_reg   <= 1'b0;
         write_enb_reg <= 1'b0;
         busy          <= 1'b0;
         wait_timeout  <= 1'b0;
      end else begin
         r_state       <= w_nextState;
         detect_add    <= (w_nextState == DECODE_ADDRESS);
         lfd_state     <= (w_nextState == LOAD_FIRST_DATA);
         ld_state      <= (w_nextState == LOAD_DATA);
         laf_state     <= (w_nextState == LOAD_AFTER_FULL);
         full_state    <= (w_nextState == FIFO_FULL_STATE);
         rst_int_reg   <= (w_nextState == CHECK_PARITY_ERROR);
         write_enb_reg <= (w_nextState == LOAD_DATA) ||
                          (w_nextState == LOAD_PARITY) ||
                          (w_nextState == LOAD_AFTER_FULL);
         busy          <= (w_nextState == LOAD_FIRST_DATA) ||
                          (w_nextState == LOAD_PARITY) ||
                          (w_nextState == FIFO_FULL_STATE) ||
                          (w_nextState == LOAD_AFTER_FULL) ||
                          (w_nextState == WAIT_TILL_EMPTY) ||
                          (w_nextState == CHECK_PARITY_ERROR);
         wait_timeout  <= w_timeoutFire && (w_nextState == DROP_PKT);
      end
   end

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// tb_router_pkt_ctrl: directed scenarios followed by randomized packets for
// router_pkt_ctrl. Expected outputs come from a packet-level plan: each packet
// is described by its port, wait length, payload length, full stalls and
// optional soft reset, and the expected phase of every cycle follows from it.
module tb_router_pkt_ctrl;

   typedef enum int {P_DA, P_LFD, P_LD, P_LAF, P_FULL, P_LP, P_CPE, P_WAIT, P_DROP, P_TOUT} phase_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pkt_valid = 1'b0;
   logic [1:0] data_in = 2'd0;
   logic       fifo_full = 1'b0;
   logic       fifo_empty_0 = 1'b1;
   logic       fifo_empty_1 = 1'b1;
   logic       fifo_empty_2 = 1'b1;
   logic       soft_reset_0 = 1'b0;
   logic       soft_reset_1 = 1'b0;
   logic       soft_reset_2 = 1'b0;
   logic       parity_done = 1'b0;
   logic       low_pkt_valid = 1'b0;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state;
   logic       rst_int_reg, write_enb_reg, busy, wait_timeout;

   int compared = 0;
   int mismatched = 0;
   int curPort = 0;
   int stepNo = 0;
   int srAt = -1;
   bit aborted = 0;

   router_pkt_ctrl #(.WAIT_LIMIT(30)) dut (
      .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full),
      .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
      .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
      .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
      .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
      .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
      .write_enb_reg(write_enb_reg), .busy(busy), .wait_timeout(wait_timeout)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Hard stop in case the run ever stalls.
   initial begin
      #900000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [1:0] rd();
      return 2'($urandom_range(0, 3));
   endfunction

   // Output pattern per phase: {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy, wait_timeout}
   function automatic logic [8:0] expOut(input phase_t ph);
      case (ph)
         P_DA:    return 9'b1_0000_0000;
         P_LFD:   return 9'b0_1000_0010;
         P_LD:    return 9'b0_0100_0100;
         P_LAF:   return 9'b0_0010_0110;
         P_FULL:  return 9'b0_0001_0010;
         P_LP:    return 9'b0_0000_0110;
         P_CPE:   return 9'b0_0000_1010;
         P_WAIT:  return 9'b0_0000_0010;
         P_DROP:  return 9'b0_0000_0000;
         default: return 9'b0_0000_0001;
      endcase
   endfunction

   task automatic checkOutput(input phase_t exp, input string tag);
      logic [8:0] obs;
      logic [8:0] req;
      obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
             rst_int_reg, write_enb_reg, busy, wait_timeout};
      req = expOut(exp);
      compared++;
      assert (obs === req) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, req);
      end
   endtask

   // Drive one cycle of inputs; ports other than the addressed one get random
   // empty and soft-reset values, which the controller must ignore.
   task automatic applyStimulus(input logic pv, input logic [1:0] din, input logic full,
                                input logic emp, input logic pdone, input logic lpv,
                                input logic sr, input int port, input phase_t exp,
                                input string tag);
      logic [2:0] e;
      logic [2:0] s;
      e = 3'($urandom);
      s = 3'($urandom);
      if (port < 3) begin
         e[port] = emp;
         s[port] = sr;
      end
      pkt_valid     = pv;
      data_in       = din;
      fifo_full     = full;
      parity_done   = pdone;
      low_pkt_valid = lpv;
      {fifo_empty_2, fifo_empty_1, fifo_empty_0} = e;
      {soft_reset_2, soft_reset_1, soft_reset_0} = s;
      @(posedge clk);
      #1;
      checkOutput(exp, tag);
   endtask

   // One in-packet cycle of a randomized packet; the planned soft reset
   // replaces the step it lands on and ends the packet.
   task automatic pktStep(input logic pv, input logic full, input logic emp,
                          input logic pdone, input logic lpv, input phase_t exp,
                          input string tag);
      logic sr;
      if (aborted) return;
      sr = (stepNo == srAt);
      stepNo++;
      applyStimulus(pv, rd(), full, emp, pdone, lpv, sr, curPort,
                    sr ? P_DA : exp, sr ? "rnd softreset" : tag);
      if (sr) aborted = 1;
   endtask

   task automatic runRandomPacket();
      int waitCyc;
      int payload;
      int k;
      int c;
      int tail;
      int idle;
      curPort = $urandom_range(0, 3);
      if (curPort == 3) begin
         k = $urandom_range(1, 5);
         applyStimulus(1, 2'd3, rb(), rb(), rb(), rb(), rb(), 3, P_DROP, "rnd drop header");
         for (int i = 0; i < k; i++)
            applyStimulus(1, rd(), rb(), rb(), rb(), rb(), rb(), 3, P_DROP, "rnd drop hold");
         applyStimulus(0, rd(), rb(), rb(), rb(), rb(), rb(), 3, P_DA, "rnd drop end");
      end else begin
         waitCyc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
         payload = $urandom_range(1, 6);
         srAt    = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 8) : -1;
         stepNo  = 0;
         aborted = 0;
         tail    = 0;
         applyStimulus(1, 2'(curPort), rb(), (waitCyc == 0), rb(), rb(), rb(), curPort,
                       (waitCyc == 0) ? P_LFD : P_WAIT, "rnd header");
         for (int i = 1; i < waitCyc; i++)
            pktStep(1, rb(), 0, rb(), rb(), P_WAIT, "rnd wait");
         if (waitCyc > 0) pktStep(1, rb(), 1, rb(), rb(), P_LFD, "rnd wait release");
         pktStep(1, rb(), rb(), rb(), rb(), P_LD, "rnd first data");
         for (int b = 0; b < payload && tail == 0; b++) begin
            if ($urandom_range(0, 3) == 0) begin
               k = $urandom_range(1, 3);
               pktStep(1, 1, rb(), rb(), rb(), P_FULL, "rnd full entry");
               for (int j = 1; j < k; j++) pktStep(rb(), 1, rb(), rb(), rb(), P_FULL, "rnd full hold");
               pktStep(rb(), 0, rb(), rb(), rb(), P_LAF, "rnd full release");
               c = $urandom_range(0, 2);
               if (c == 0) pktStep(1, rb(), rb(), 0, 0, P_LD, "rnd laf resume");
               else if (c == 1) begin
                  pktStep(rb(), rb(), rb(), 0, 1, P_LP, "rnd laf lowpv");
                  tail = 1;
               end else begin
                  pktStep(rb(), rb(), rb(), 1, rb(), P_DA, "rnd laf parity done");
                  tail = 2;
               end
            end else begin
               pktStep(1, 0, rb(), rb(), rb(), P_LD, "rnd payload");
            end
         end
         if (tail == 0) pktStep(0, 0, rb(), rb(), rb(), P_LP, "rnd parity");
         if (tail <= 1) begin
            pktStep(rb(), rb(), rb(), rb(), rb(), P_CPE, "rnd check parity");
            if ($urandom_range(0, 3) == 0) begin
               pktStep(rb(), 1, rb(), rb(), rb(), P_FULL, "rnd cpe full");
               pktStep(rb(), 0, rb(), rb(), rb(), P_LAF, "rnd cpe release");
               pktStep(rb(), rb(), rb(), 1, rb(), P_DA, "rnd cpe parity done");
            end else begin
               pktStep(rb(), 0, rb(), rb(), rb(), P_DA, "rnd cpe done");
            end
         end
      end
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++)
         applyStimulus(0, rd(), rb(), rb(), rb(), rb(), rb(), curPort, P_DA, "rnd idle");
   endtask

   initial begin
      // Reset with arbitrary inputs must hold DECODE_ADDRESS.
      reset = 1'b1;
      applyStimulus(1, 2'd1, 1, 1, 1, 1, 1, 1, P_DA, "reset 0");
      applyStimulus(1, 2'd3, 0, 0, 0, 0, 0, 0, P_DA, "reset 1");
      reset = 1'b0;
      applyStimulus(0, 2'd0, 0, 0, 0, 0, 0, 1, P_DA, "idle after reset");

      // Basic packet to port 1.
      applyStimulus(1, 2'd1, 0, 1, 0, 0, 0, 1, P_LFD, "p1 header");
      applyStimulus(1, 2'd2, 0, 0, 0, 0, 0, 1, P_LD, "p1 first data");
      applyStimulus(0, 2'd3, 0, 0, 0, 0, 0, 1, P_LP, "p1 parity");
      applyStimulus(0, 2'd0, 0, 0, 0, 0, 0, 1, P_CPE, "p1 check parity");
      applyStimulus(0, 2'd0, 0, 0, 0, 0, 0, 1, P_DA, "p1 back to decode");

      // Port 0 not empty: wait, then load; full stall, then low_pkt_valid.
      applyStimulus(1, 2'd0, 0, 0, 0, 0, 0, 0, P_WAIT, "p0 wait entry");
      applyStimulus(1, 2'd1, 0, 0, 0, 0, 0, 0, P_WAIT, "p0 wait hold");
      applyStimulus(1, 2'd0, 0, 1, 0, 0, 0, 0, P_LFD, "p0 wait release");
      applyStimulus(1, 2'd0, 0, 0, 0, 0, 0, 0, P_LD, "p0 first data");
      applyStimulus(1, 2'd0, 1, 0, 0, 0, 0, 0, P_FULL, "p0 full 1");
      applyStimulus(1, 2'd0, 1, 0, 0, 0, 0, 0, P_FULL, "p0 full 2");
      applyStimulus(1, 2'd0, 1, 0, 0, 0, 0, 0, P_FULL, "p0 full 3");
      applyStimulus(1, 2'd0, 0, 0, 0, 0, 0, 0, P_LAF, "p0 after full");
      applyStimulus(0, 2'd0, 0, 0, 0, 1, 0, 0, P_LP, "p0 laf lowpv");
      applyStimulus(0, 2'd0, 0, 0, 0, 0, 0, 0, P_CPE, "p0 check parity");
      applyStimulus(0, 2'd0, 0, 0, 0, 0, 0, 0, P_DA, "p0 done");

      // fifo_full beats !pkt_valid in LOAD_DATA; parity_done ends it.
      applyStimulus(1, 2'd1, 0, 1, 0, 0, 0, 1, P_LFD, "ff header");
      applyStimulus(1, 2'd1, 0, 1, 0, 0, 0, 1, P_LD, "ff first data");
      applyStimulus(0, 2'd1, 1, 1, 0, 0, 0, 1, P_FULL, "ff full beats parity");
      applyStimulus(0, 2'd1, 0, 1, 0, 0, 0, 1, P_LAF, "ff release");
      applyStimulus(0, 2'd1, 0, 1, 1, 1, 0, 1, P_DA, "ff parity done wins");

      // CHECK_PARITY_ERROR with fifo_full goes to FIFO_FULL_STATE.
      applyStimulus(1, 2'd2, 0, 1, 0, 0, 0, 2, P_LFD, "cpe header");
      applyStimulus(1, 2'd2, 0, 1, 0, 0, 0, 2, P_LD, "cpe first data");
      applyStimulus(0, 2'd2, 0, 1, 0, 0, 0, 2, P_LP, "cpe parity");
      applyStimulus(0, 2'd2, 0, 1, 0, 0, 0, 2, P_CPE, "cpe check");
      applyStimulus(0, 2'd2, 1, 1, 0, 0, 0, 2, P_FULL, "cpe full");
      applyStimulus(0, 2'd2, 0, 1, 0, 0, 0, 2, P_LAF, "cpe release");
      applyStimulus(0, 2'd2, 0, 1, 1, 0, 0, 2, P_DA, "cpe parity done");

      // Invalid address: drop while pkt_valid is held five cycles.
      applyStimulus(1, 2'd3, 0, 1, 0, 0, 0, 3, P_DROP, "drop header");
      for (int i = 0; i < 4; i++)
         applyStimulus(1, rd(), 0, 1, 0, 0, 0, 3, P_DROP, "drop hold");
      applyStimulus(0, 2'd0, 0, 1, 0, 0, 0, 3, P_DA, "drop end");

      // Port 2 soft reset in LOAD_DATA; other ports' soft resets are noise.
      applyStimulus(1, 2'd2, 0, 1, 0, 0, 0, 2, P_LFD, "sr header");
      applyStimulus(1, 2'd0, 0, 1, 0, 0, 0, 2, P_LD, "sr first data");
      for (int i = 0; i < 3; i++)
         applyStimulus(1, rd(), 0, rb(), 0, 0, 0, 2, P_LD, "sr other ports ignored");
      applyStimulus(1, 2'd1, 0, 1, 0, 0, 1, 2, P_DA, "sr port2 aborts");

      // Soft reset and empty in the same WAIT cycle: soft reset wins.
      applyStimulus(1, 2'd0, 0, 0, 0, 0, 0, 0, P_WAIT, "srw wait entry");
      applyStimulus(1, 2'd0, 0, 1, 0, 0, 1, 0, P_DA, "srw soft reset wins");

      // Hard reset mid-packet.
      applyStimulus(1, 2'd1, 0, 1, 0, 0, 0, 1, P_LFD, "rst header");
      applyStimulus(1, 2'd1, 0, 1, 0, 0, 0, 1, P_LD, "rst first data");
      reset = 1'b1;
      applyStimulus(1, 2'd1, 1, 1, 0, 0, 0, 1, P_DA, "rst mid packet");
      reset = 1'b0;
      applyStimulus(0, 2'd0, 0, 1, 0, 0, 0, 1, P_DA, "rst idle");

      // Long wait on a busy port 1.
      applyStimulus(1, 2'd1, 0, 0, 0, 0, 0, 1, P_WAIT, "tmo wait entry");
`ifdef ROUTER_CTRL_WAIT_TIMEOUT_EN
      for (int i = 1; i < 30; i++)
         applyStimulus(1, rd(), rb(), 0, rb(), rb(), 0, 1, P_WAIT, "tmo waiting");
      applyStimulus(1, rd(), rb(), 0, rb(), rb(), 0, 1, P_TOUT, "tmo fire");
      applyStimulus(1, rd(), rb(), 0, rb(), rb(), 0, 1, P_DROP, "tmo pulse ends");
      applyStimulus(0, rd(), rb(), 0, rb(), rb(), 0, 1, P_DA, "tmo drop end");
`else
      for (int i = 0; i < 100; i++)
         applyStimulus(1, rd(), rb(), 0, rb(), rb(), 0, 1, P_WAIT, "tmo still waiting");
      applyStimulus(1, rd(), rb(), 1, rb(), rb(), 0, 1, P_LFD, "tmo release");
      applyStimulus(1, rd(), rb(), 1, rb(), rb(), 0, 1, P_LD, "tmo first data");
      applyStimulus(0, rd(), 0, 1, rb(), rb(), 0, 1, P_LP, "tmo parity");
      applyStimulus(0, rd(), rb(), 1, rb(), rb(), 0, 1, P_CPE, "tmo check");
      applyStimulus(0, rd(), 0, 1, rb(), rb(), 0, 1, P_DA, "tmo done");
`endif

      // Randomized packets.
      for (int n = 0; n < 150; n++) runRandomPacket();

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
